// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces the scanner's key_value/key_valid pair,
// emits one-cycle press strobes with auto-repeat on held digits, and drives a
// BCD operand entry buffer with operator latch, clear and enter handling.
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYC = 800000,
  parameter int REPEAT_DLY   = 50000000,
  parameter int REPEAT_RATE  = 10000000,
  parameter int NUM_DIGITS   = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [3:0]                      key_value,
  input  logic                            key_valid,
  output logic                            key_event,
  output logic [3:0]                      key_code,
  output logic                            key_repeat,
  output logic [4*NUM_DIGITS-1:0]         entry_bcd,
  output logic [$clog2(NUM_DIGITS+1)-1:0] entry_count,
  output logic                            entry_ovf,
  output logic [1:0]                      op_code,
  output logic                            op_valid,
  output logic [4*NUM_DIGITS-1:0]         operand,
  output logic                            operand_stb,
  output logic                            enter_stb
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  // Debounce counter only ever needs to reach DEBOUNCE_CYC-1.
  localparam int DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'((DEBOUNCE_CYC > 1) ? DEBOUNCE_CYC - 1 : 0);
  localparam logic [DW-1:0] DEB_SAT  = '1;
  localparam logic [DW-1:0] ONE_D    = 1;

  // Repeat counter is sized for the larger of the two repeat intervals.
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW      = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
  localparam logic [RW-1:0] DLY_LAST  = RW'((REPEAT_DLY > 1) ? REPEAT_DLY - 1 : 0);
  localparam logic [RW-1:0] RATE_LAST = RW'((REPEAT_RATE > 1) ? REPEAT_RATE - 1 : 0);
  localparam logic [RW-1:0] REP_SAT   = '1;
  localparam logic [RW-1:0] ONE_R     = 1;
  localparam bit            REP_EN    = (REPEAT_DLY != 0);

  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_DIGITS);
  localparam logic [CW-1:0] ONE_C    = 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [3:0] c);
    return (c <= 4'd9);
  endfunction

  function automatic logic [1:0] op_map(input logic [3:0] c);
    logic [1:0] r;
    case (c)
      4'ha:    r = 2'd0;
      4'hb:    r = 2'd1;
      4'he:    r = 2'd2;
      4'hd:    r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Registered scanner inputs
  logic [3:0]    kvalue_q, kvalue_d;
  logic          kvalid_q, kvalid_d;

  // Key FSM state
  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [3:0]    cap_q, cap_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rfirst_q, rfirst_d;
  logic          key_event_q, key_event_d;
  logic          key_repeat_q, key_repeat_d;
  logic [3:0]    key_code_q, key_code_d;

  // Entry buffer state
  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] ecnt_q, ecnt_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    opc_q, opc_d;
  logic          opv_q, opv_d;
  logic [BW-1:0] operand_q, operand_d;
  logic          ostb_q, ostb_d;
  logic          estb_q, estb_d;

  logic          same_key;
  logic [DW-1:0] cnt_inc;
  logic [RW-1:0] rcnt_inc;
  logic [RW-1:0] rep_lim;

  // Scanner inputs are registered once; every decision uses these copies.
  always_comb begin
    kvalue_d = key_value;
    kvalid_d = key_valid;
  end

  // Key FSM next-state: debounce press/release and time auto-repeat.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_d        = cap_q;
    rcnt_d       = rcnt_q;
    rfirst_d     = rfirst_q;
    key_event_d  = 1'b0;
    key_repeat_d = 1'b0;
    key_code_d   = key_code_q;
    same_key     = kvalid_q && (kvalue_q == cap_q);
    cnt_inc      = (cnt_q == DEB_SAT) ? cnt_q : cnt_q + ONE_D;
    rcnt_inc     = (rcnt_q == REP_SAT) ? rcnt_q : rcnt_q + ONE_R;
    rep_lim      = rfirst_q ? DLY_LAST : RATE_LAST;

    case (state_q)
      IDLE: begin
        if (kvalid_q) begin
          cap_d   = kvalue_q;
          cnt_d   = '0;
          state_d = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (!same_key) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DEB_LAST) begin
            state_d     = HELD;
            key_event_d = 1'b1;
            key_code_d  = cap_q;
            rcnt_d      = '0;
            rfirst_d    = 1'b1;
          end
        end
      end
      HELD: begin
        if (!same_key) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end else if (REP_EN && is_digit(cap_q)) begin
          if (rcnt_q >= rep_lim) begin
            key_event_d  = 1'b1;
            key_repeat_d = 1'b1;
            key_code_d   = cap_q;
            rcnt_d       = '0;
            rfirst_d     = 1'b0;
          end else begin
            rcnt_d = rcnt_inc;
          end
        end
      end
      DEB_RELEASE: begin
        // Same key back: resume holding with a fresh repeat delay.
        // A different key must fully release before it can be accepted.
        if (same_key) begin
          state_d  = HELD;
          rcnt_d   = '0;
          rfirst_d = 1'b1;
        end else if (kvalid_q) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DEB_LAST) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry buffer next-state: act on the previous cycle's key event.
  always_comb begin
    buf_d     = buf_q;
    ecnt_d    = ecnt_q;
    ovf_d     = ovf_q;
    opc_d     = opc_q;
    opv_d     = opv_q;
    operand_d = operand_q;
    ostb_d    = 1'b0;
    estb_d    = 1'b0;

    if (key_event_q) begin
      if (is_digit(key_code_q)) begin
        if (ecnt_q >= CNT_FULL) begin
          ovf_d = 1'b1;
        end else begin
          buf_d  = (buf_q << 4) | BW'(key_code_q);
          ecnt_d = ecnt_q + ONE_C;
        end
      end else begin
        case (key_code_q)
          4'hc: begin
            buf_d  = '0;
            ecnt_d = '0;
            ovf_d  = 1'b0;
            opv_d  = 1'b0;
            opc_d  = 2'd0;
          end
          4'ha, 4'hb, 4'he, 4'hd: begin
            operand_d = buf_q;
            ostb_d    = 1'b1;
            opc_d     = op_map(key_code_q);
            opv_d     = 1'b1;
            buf_d     = '0;
            ecnt_d    = '0;
            ovf_d     = 1'b0;
          end
          4'hf: begin
            operand_d = buf_q;
            estb_d    = 1'b1;
            buf_d     = '0;
            ecnt_d    = '0;
            ovf_d     = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Input registers and key FSM state, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kvalue_q     <= '0;
      kvalid_q     <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      cap_q        <= '0;
      rcnt_q       <= '0;
      rfirst_q     <= 1'b0;
      key_event_q  <= 1'b0;
      key_repeat_q <= 1'b0;
      key_code_q   <= '0;
    end else begin
      kvalue_q     <= kvalue_d;
      kvalid_q     <= kvalid_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_q        <= cap_d;
      rcnt_q       <= rcnt_d;
      rfirst_q     <= rfirst_d;
      key_event_q  <= key_event_d;
      key_repeat_q <= key_repeat_d;
      key_code_q   <= key_code_d;
    end
  end

  // Entry buffer, operator latch and strobes, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_q     <= '0;
      ecnt_q    <= '0;
      ovf_q     <= 1'b0;
      opc_q     <= 2'd0;
      opv_q     <= 1'b0;
      operand_q <= '0;
      ostb_q    <= 1'b0;
      estb_q    <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      ecnt_q    <= ecnt_d;
      ovf_q     <= ovf_d;
      opc_q     <= opc_d;
      opv_q     <= opv_d;
      operand_q <= operand_d;
      ostb_q    <= ostb_d;
      estb_q    <= estb_d;
    end
  end

  assign key_event   = key_event_q;
  assign key_code    = key_code_q;
  assign key_repeat  = key_repeat_q;
  assign entry_bcd   = buf_q;
  assign entry_count = ecnt_q;
  assign entry_ovf   = ovf_q;
  assign op_code     = opc_q;
  assign op_valid    = opv_q;
  assign operand     = operand_q;
  assign operand_stb = ostb_q;
  assign enter_stb   = estb_q;

endmodule
